packer_k_to_n_stream: RTL
=========================

Name: packer_k_to_n_stream

Overview:
- Parametrised successor to the fixed K-to-N data packer.
- Gathers FACTOR consecutive IN_WIDTH-bit beats into one FACTOR*IN_WIDTH-bit word.
- Adds valid/ready handshakes on both sides, backpressure, early termination of a partial word via in_last, and per-lane keep flags.
- Sits between a narrow streaming source (ADC/serial deserialiser) and a wide bus/FIFO write port.

Parameters:
- IN_WIDTH, 8, width of one input beat in bits; must be ≥1.
- FACTOR, 3, number of input beats per output word; must be ≥2.
- OUT_WIDTH, FACTOR*IN_WIDTH, derived output width; do not override.
- CNT_W, $clog2(FACTOR), derived lane-counter width; do not override.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_WIDTH  input beat.
- in_valid  in  1  in_data is valid.
- in_last  in  1  this beat closes the current word, even if it is partial.
- in_ready  out  1  packer accepts a beat this cycle.
- out_data  out  OUT_WIDTH  packed word.
- out_keep  out  FACTOR  one bit per lane; 1 = lane holds real data.
- out_last  out  1  word was closed by in_last.
- out_valid  out  1  out_data/out_keep/out_last are valid.
- out_ready  in  1  sink accepts the word.

Behaviour:
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output word transferred when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
- Lane counter lane_cnt (0..FACTOR-1) selects the lane for the next accepted beat.
  - Lane i occupies bits [i*IN_WIDTH +: IN_WIDTH].
  - Lane 0 = first beat (LSB-first).
- Accumulator acc[OUT_WIDTH] and keep_acc[FACTOR].
  - On accept: write in_data to lane lane_cnt and set keep_acc[lane_cnt].
- Word close: an accepted beat with lane_cnt==FACTOR-1, or with in_last=1. On the same edge:
  - out_data <= acc with the current beat merged in.
  - out_keep <= keep_acc with the current bit set.
  - out_last <= in_last.
  - out_valid <= 1.
  - acc, keep_acc and lane_cnt are cleared.
- Latency: out_valid asserts 1 cycle after the closing beat is accepted.
- Throughput: 1 beat/cycle sustained while out_ready=1; no bubble between words.
- Unused lanes of a partial word read 0 in out_data; their out_keep bits are 0.
- in_last on lane 0 gives a word with out_keep = 'b0…01.
- out_valid is cleared on transfer unless a new word closes on the same edge, in which case out_valid stays 1 and the output fields take the new word.
- While out_valid && !out_ready:
  - in_ready=0; accumulator and counter hold.
  - out_data, out_keep and out_last stay stable (AXI-style rule).
- in_valid without in_ready: no state change.
- Reset (any time, including mid-word): out_data=0, out_keep=0, out_last=0, out_valid=0, acc=0, keep_acc=0, lane_cnt=0. Partial data is discarded.
- After reset release, in_ready=1 in the first cycle.

Optional Feature:
- Macro PACKER_MSB_FIRST_EN.
- Defined: first beat lands in lane FACTOR-1 (top bits) and the lane index counts down.
  - out_keep bit mapping follows the physical lane.
  - Partial words are left-aligned: upper lanes valid, lower lanes 0.
- Undefined: LSB-first mapping as above.
- Handshake timing and latency are identical in both builds.

Decomposition:
- Package packer_pkg:
  - function lane_lo(idx, IN_WIDTH) returning the bit offset.
  - Localparam defaults DEF_IN_WIDTH=8, DEF_FACTOR=3.
- One sub-module, packer_out_reg: the output holding register with valid/ready and the stable-while-stalled rule. It is reusable by future unpackers.
- Counter and accumulator stay in the top module.

Test Plan (FACTOR=3, IN_WIDTH=8, LSB-first unless stated):
- Continuous stream 1A,2A,3A,4A,5A,6A with out_ready=1 -> words 0x3A2A1A then 0x6A5A4A; keep=3'b111; last=0. Each word appears 1 cycle after its 3rd beat; in_ready is never low.
- Beats 1A,2A with in_last on 2A -> out_data=0x002A1A, keep=3'b011, last=1. Next beat 7A lands in lane 0.
- Backpressure: out_ready=0 for 5 cycles after first word, source streams continuously -> in_ready=0 throughout; out_data holds 0x3A2A1A stable. The 4th beat is accepted on the cycle out_ready returns, with no data loss or reordering.
- rst asserted asynchronously after beat 2 of a word, then released -> all outputs 0. The next three beats 9A,AA,BA give 0xBAAA9A.
- in_valid toggled 1/0 every cycle over 3 beats -> single word, correct value, lane order preserved.
- PACKER_MSB_FIRST_EN build, beats 1A,2A,3A -> 0x1A2A3A. Beats 1A with in_last -> 0x1A0000, keep=3'b100.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared types and helpers for the K-to-N stream packer.
// Lane order is selected at build time by PACKER_MSB_FIRST_EN.
package packer_pkg;

  localparam int unsigned DEF_IN_WIDTH = 8;
  localparam int unsigned DEF_FACTOR   = 3;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

`ifdef PACKER_MSB_FIRST_EN
  localparam lane_order_e LANE_ORDER = LANE_MSB_FIRST;
`else
  localparam lane_order_e LANE_ORDER = LANE_LSB_FIRST;
`endif

  function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Output holding register with valid/ready; fields stay stable while stalled.
// A new word may be loaded on the same edge the current one is transferred.
module packer_out_reg #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned KEEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic              can_load,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load && can_load) begin
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packer_k_to_n_stream.sv
// Packs FACTOR IN_WIDTH-bit beats into one word with keep flags and in_last closure.
// Define PACKER_MSB_FIRST_EN to place the first beat in the top lane.
module packer_k_to_n_stream
  import packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned FACTOR    = DEF_FACTOR,
  parameter int unsigned OUT_WIDTH = FACTOR * IN_WIDTH,
  parameter int unsigned CNT_W     = $clog2(FACTOR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [FACTOR-1:0]    out_keep,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [CNT_W-1:0]     lane_cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [FACTOR-1:0]    keep_acc;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [FACTOR-1:0]    merged_keep;
  logic                 accept;
  logic                 close_word;
  int unsigned          phys_lane;

  assign accept     = in_valid && in_ready;
  assign close_word = accept && ((lane_cnt == CNT_W'(FACTOR - 1)) || in_last);

  // lane_cnt always counts beats upward; the physical lane is derived from it.
  always_comb begin
    if (LANE_ORDER == LANE_MSB_FIRST) begin
      phys_lane = FACTOR - 1 - 32'(lane_cnt);
    end else begin
      phys_lane = 32'(lane_cnt);
    end
    merged_data = acc;
    merged_keep = keep_acc;
    for (int unsigned i = 0; i < FACTOR; i++) begin
      if (i == phys_lane) begin
        merged_data[lane_lo(i, IN_WIDTH) +: IN_WIDTH] = in_data;
        merged_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      acc      <= '0;
      keep_acc <= '0;
    end else if (accept) begin
      if (close_word) begin
        lane_cnt <= '0;
        acc      <= '0;
        keep_acc <= '0;
      end else begin
        lane_cnt <= lane_cnt + CNT_W'(1);
        acc      <= merged_data;
        keep_acc <= merged_keep;
      end
    end
  end

  packer_out_reg #(
    .DATA_W(OUT_WIDTH),
    .KEEP_W(FACTOR)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (close_word),
    .load_data (merged_data),
    .load_keep (merged_keep),
    .load_last (in_last),
    .can_load  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
